// File: rtl/bus_codec_pkg.sv
// Shared constants and types for the control-bus address codec pair.
// The decoder and this encoder both pull their default sizes from here.
package bus_codec_pkg;

    localparam int BUS_ADDR_WIDTH = 3;
    localparam int BUS_NUM_LINES  = 6;

    typedef enum logic {
        ENC_IDLE,
        ENC_GRANT
    } enc_state_t;

endpackage

// File: rtl/req_addr_encoder_rr_pick.sv
// Round-robin picker: first set bit of pending at or above ptr, wrapping
// from num_lines-1 back to 0. Purely combinational.
module rr_pick
    import bus_codec_pkg::*;
#(
    parameter int addr_width = BUS_ADDR_WIDTH,
    parameter int num_lines  = BUS_NUM_LINES
) (
    input  logic [num_lines-1:0]  pending,
    input  logic [addr_width-1:0] ptr,
    output logic [addr_width-1:0] idx,
    output logic                  any
);

    // Scan from the farthest offset down to offset 0, so the nearest hit wins.
    always_comb begin
        int base;
        int c;
        idx  = '0;
        any  = 1'b0;
        base = (int'(ptr) < num_lines) ? int'(ptr) : 0;
        c    = 0;
        for (int k = num_lines - 1; k >= 0; k--) begin
            c = base + k;
            if (c >= num_lines) c = c - num_lines;
            if (pending[c]) begin
                idx = addr_width'(c);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_addr_encoder.sv
// Round-robin request-to-address encoder. Rising edges on req become sticky
// pending bits; one winner at a time is presented as address + one-hot grant
// under a valid/ack handshake, with one idle cycle between grants.
module req_addr_encoder
    import bus_codec_pkg::*;
#(
    parameter int addr_width = BUS_ADDR_WIDTH,
    parameter int num_lines  = BUS_NUM_LINES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [num_lines-1:0]  req,
    input  logic                  ack,
    output logic [addr_width-1:0] address,
    output logic                  valid,
    output logic [num_lines-1:0]  grant,
    output logic [num_lines-1:0]  pending
);

    enc_state_t            state_q, state_d;
    logic [addr_width-1:0] address_q, address_d;
    logic                  valid_q, valid_d;
    logic [num_lines-1:0]  grant_q, grant_d;
    logic [num_lines-1:0]  pending_q, pending_d;
    logic [addr_width-1:0] ptr_q, ptr_d;
    logic [num_lines-1:0]  req_d_q, req_d_d;

    logic [num_lines-1:0]  rise;
    logic [num_lines-1:0]  clr;
    logic [addr_width-1:0] pick_idx;
    logic                  pick_any;

    // Selection looks only at registered pending, so a fresh rise waits a cycle.
    rr_pick #(
        .addr_width (addr_width),
        .num_lines  (num_lines)
    ) u_pick (
        .pending (pending_q),
        .ptr     (ptr_q),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    // Next-state: edge detect, pending set/clear (set wins), grant FSM.
    always_comb begin
        rise      = req & ~req_d_q;
        req_d_d   = req;
        state_d   = state_q;
        address_d = address_q;
        valid_d   = valid_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        clr       = '0;
        case (state_q)
            ENC_IDLE: begin
                if (pick_any) begin
                    address_d = pick_idx;
                    for (int i = 0; i < num_lines; i++)
                        grant_d[i] = (pick_idx == addr_width'(i));
                    valid_d   = 1'b1;
                    state_d   = ENC_GRANT;
                end
            end
            ENC_GRANT: begin
                if (ack) begin
                    for (int i = 0; i < num_lines; i++)
                        clr[i] = (address_q == addr_width'(i));
                    ptr_d   = (int'(address_q) >= num_lines - 1) ? '0 : address_q + 1'b1;
                    valid_d = 1'b0;
                    grant_d = '0;
                    state_d = ENC_IDLE;
                end
            end
            default: state_d = ENC_IDLE;
        endcase
        pending_d = (pending_q & ~clr) | rise;
    end

    // State and output registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ENC_IDLE;
            address_q <= '0;
            valid_q   <= 1'b0;
            grant_q   <= '0;
            pending_q <= '0;
            ptr_q     <= '0;
            req_d_q   <= '0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            valid_q   <= valid_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            req_d_q   <= req_d_d;
        end
    end

    assign address = address_q;
    assign valid   = valid_q;
    assign grant   = grant_q;
    assign pending = pending_q;

    // The address field must be able to name every line.
    param_chk: assert property (@(posedge clk) (2 ** addr_width) >= num_lines);

endmodule

// File: tb/tb_req_addr_encoder.sv
// Bench for req_addr_encoder: directed scenarios with literal expectations,
// then randomized req/ack/reset traffic checked every cycle against a model.
module tb_req_addr_encoder;

    localparam int AW = 3;
    localparam int NL = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [NL-1:0] req = '0;
    logic          ack = 1'b0;
    logic [AW-1:0] address;
    logic          valid;
    logic [NL-1:0] grant;
    logic [NL-1:0] pending;

    int checks = 0;
    int errors = 0;

    req_addr_encoder #(.addr_width(AW), .num_lines(NL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .ack     (ack),
        .address (address),
        .valid   (valid),
        .grant   (grant),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Behavioural model: set of pending lines, a pointer, and the current grant.
    bit [NL-1:0] m_pend, m_reqd;
    int          m_ptr, m_addr;
    bit          m_valid;

    always @(posedge clk or negedge reset_n) begin : model
        bit [NL-1:0] rise;
        int          win;
        if (!reset_n) begin
            m_pend = '0; m_reqd = '0; m_ptr = 0; m_addr = 0; m_valid = 0;
        end else begin
            rise = req & ~m_reqd;
            win  = -1;
            if (m_valid) begin
                if (ack) begin
                    m_pend[m_addr] = 1'b0;
                    m_ptr   = (m_addr + 1) % NL;
                    m_valid = 0;
                end
            end else begin
                for (int k = 0; k < NL; k++)
                    if (win < 0 && m_pend[(m_ptr + k) % NL]) win = (m_ptr + k) % NL;
                if (win >= 0) begin
                    m_addr  = win;
                    m_valid = 1;
                end
            end
            m_pend = m_pend | rise;
            m_reqd = req;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("address", int'(address), m_addr);
        chk("valid",   int'(valid),   int'(m_valid));
        chk("grant",   int'(grant),   m_valid ? (1 << m_addr) : 0);
        chk("pending", int'(pending), int'(m_pend));
    end

    initial begin
        // Reset with all requests high
        #1 reset_n = 1'b0;
        req = 6'b111111;
        repeat (3) tick();
        chk("rst_valid", int'(valid), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_address", int'(address), 0);
        reset_n = 1'b1;
        tick();
        chk("rel_pending", int'(pending), 6'b111111);
        chk("rel_valid", int'(valid), 0);
        tick();
        chk("rel_grant", int'(grant), 6'b000001);
        // Drain all six in order with ack held high
        ack = 1'b1;
        for (int k = 0; k < NL; k++) begin
            chk("drain_addr", int'(address), k);
            chk("drain_valid", int'(valid), 1);
            tick();
            chk("drain_dead", int'(valid), 0);
            tick();
        end
        chk("drain_pending", int'(pending), 0);
        ack = 1'b0;
        req = '0;
        tick();

        // Single request on line 4
        req = 6'b010000;
        tick();
        chk("single_pend", int'(pending), 6'b010000);
        chk("single_v0", int'(valid), 0);
        tick();
        chk("single_addr", int'(address), 4);
        chk("single_grant", int'(grant), 6'b010000);
        repeat (2) tick();
        chk("single_hold", int'(valid), 1);
        ack = 1'b1;
        tick();
        chk("single_ack_v", int'(valid), 0);
        chk("single_ack_p", int'(pending), 0);
        ack = 1'b0;

        // Wrap: ptr=5 grants line 2; then ptr=3 picks 4 before 1
        req = '0;
        tick();
        req = 6'b000100;
        tick();
        tick();
        chk("wrap_addr2", int'(address), 2);
        ack = 1'b1;
        req = '0;
        tick();
        ack = 1'b0;
        req = 6'b010010;
        tick();
        chk("fair_pend", int'(pending), 6'b010010);
        tick();
        chk("fair_first", int'(address), 4);
        ack = 1'b1;
        tick();
        tick();
        chk("fair_second", int'(address), 1);
        chk("fair_second_v", int'(valid), 1);
        tick();
        chk("fair_done", int'(pending), 0);
        ack = 1'b0;
        req = '0;
        tick();

        // Collision: rise on line 2 coinciding with its ack (ptr=2)
        req = 6'b000100;
        tick();
        tick();
        chk("coll_addr", int'(address), 2);
        req = '0;
        tick();
        req = 6'b000100;
        ack = 1'b1;
        tick();
        chk("coll_v0", int'(valid), 0);
        chk("coll_pend", int'(pending), 6'b000100);
        ack = 1'b0;
        tick();
        chk("coll_regrant", int'(address), 2);
        chk("coll_regrant_v", int'(valid), 1);
        // Second rise while pending merges into the same request
        req = '0;
        tick();
        req = 6'b000100;
        tick();
        ack = 1'b1;
        tick();
        chk("merge_pend", int'(pending), 0);
        ack = 1'b0;
        tick();
        chk("merge_nogrant", int'(valid), 0);
        req = '0;
        tick();

        // Reset while a grant is outstanding (ptr=3)
        req = 6'b001011;
        tick();
        tick();
        chk("mid_addr", int'(address), 3);
        req = '0;
        reset_n = 1'b0;
        #1;
        chk("mid_valid", int'(valid), 0);
        chk("mid_pending", int'(pending), 0);
        chk("mid_grant", int'(grant), 0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk("mid_after_v", int'(valid), 0);
        chk("mid_after_p", int'(pending), 0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            req = req ^ NL'($urandom_range(0, 63) & $urandom_range(0, 63) & $urandom_range(0, 63));
            ack = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end else begin
                tick();
            end
        end
        ack = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_addr_encoder.md
# req_addr_encoder

Round-robin request-to-address encoder, the inverse of the registered one-hot address decoder on the internal control bus. Collects edge-triggered service requests from up to `num_lines` sources, buffers them as sticky pending bits, and presents one winning index at a time as a binary address plus a registered one-hot grant. The consumer takes the address under a valid/ack handshake. Sits between the voice/peripheral request lines and the bus master that issues the decoded select.

## Interface
- `addr_width`, 3, width of the encoded address; `2**addr_width >= num_lines` is required and is checked by a simulation-only assertion.
- `num_lines`, 6, number of request sources.

- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req`  in  num_lines  level request lines; a rising edge raises a request.
- `ack`  in  1  consumer accepts the current address; sampled only while `valid`=1.
- `address`  out  addr_width  index of the granted line; registered.
- `valid`  out  1  `address` and `grant` are meaningful; registered.
- `grant`  out  num_lines  one-hot of the granted line; all zeros when idle; registered.
- `pending`  out  num_lines  sticky pending request bits; registered, for status/debug.

## Operation
- **Edge detect.** `req_d` holds `req` delayed one cycle. `rise = req & ~req_d`.
- **Pending set.** `pending[i]` sets on `rise[i]`.
- **Pending clear.** `pending[i]` clears when the FSM is in GRANT, `ack`=1, and `address`==i.
- **Set/clear collision.** On the same cycle, set wins and the line stays pending.
- **Merged requests.** Repeated rises on a line that is already pending merge into one request. There is no count.
- **Round-robin pointer.** `ptr` (addr_width bits) selects the first pending index at or above `ptr`, wrapping from `num_lines-1` to 0.
- **Ignored bits.** Pending bits with index >= `num_lines` do not exist.
- **FSM state IDLE.**
  - `valid`=0, `grant`=0.
  - If `pending`≠0: load `address` with the winning index, set `grant` to its one-hot, set `valid`=1, go to GRANT.
  - Selection uses the registered `pending` value, so a rise arriving this cycle is not visible until the next cycle.
- **FSM state GRANT.**
  - `address`, `grant` and `valid` are held stable until `ack`=1.
  - On `ack`: clear that pending bit (subject to the collision rule), set `ptr` to `address+1` (wrap to 0 at `num_lines`), set `valid`=0 and `grant`=0, go to IDLE.
- **Dead cycle.** There is always exactly one IDLE cycle between consecutive grants.
- **`ack` outside GRANT** is ignored.
- **`req` falling** has no effect.

## Timing
- **Reset values.** All outputs are 0: `address`=0, `valid`=0, `grant`=0, `pending`=0. `ptr`=0, `req_d`=0, state IDLE.
- **Reset mid-operation.** Asserting `reset_n` low forces the reset values asynchronously. In-flight and pending requests are discarded.
- **After reset release.** A `req` line already high is seen as a rise on the first clock edge.
- **Request latency.** `req[i]` is first sampled high at edge E. `pending[i]`=1 after E. `valid`=1 after E+1 if the FSM is idle and line i wins.
- **Ack latency.** `ack` sampled at edge A gives `valid`=0 after A. The next grant, if any line is pending, appears after A+1.
- **Throughput.** One grant per 2 cycles minimum.

## Structure
- **Shared package `bus_codec_pkg`:** `typedef enum logic {ENC_IDLE, ENC_GRANT} enc_state_t;`. The same package gets the decoder's default `addr_width` and `num_lines` constants so both ends agree.
- **Sub-module `rr_pick`:** combinational. Inputs `pending` and `ptr`; outputs `idx` (addr_width) and `any`. Parameterised identically.
- **Top level:** edge detect, pending register, FSM and output registers.

## Test plan
- **Reset:** hold `reset_n` low with `req`=6'b111111 → all outputs 0. Release → `pending`=6'b111111 after the first edge, then `address`=0, `grant`=6'b000001, `valid`=1 one edge later.
- **Single request:** rise on `req[4]` at edge 10 → `pending`=6'b010000 after 10; `valid`=1, `address`=4, `grant`=6'b010000 after 11. `ack` at 14 → `valid`=0, `pending`=0, `ptr`=5 after 14.
- **Simultaneous requests:** rises on lines 0, 2 and 5 in the same cycle with `ptr`=0, `ack` held high → grants 0, 2, 5 with one dead cycle between each. `ptr` ends at 0 (wrapped from 5).
- **Fairness/wrap:** `ptr`=3, pending lines 1 and 4 → line 4 is granted first, then line 1. `ptr` ends at 2.
- **Collision:** `req[2]` rises on the same cycle as `ack` for address 2 → `pending[2]` stays 1 and line 2 is re-granted after the dead cycle. A second rise while pending merges (only one grant).
- **Reset mid-grant:** assert `reset_n` low while `valid`=1 with 3 lines pending → immediate zero outputs. No grant appears after release unless `req` is still high.
